// File: rtl/scp_pkg.sv
// Shared types and constants for the scp instruction-fetch front end.
package scp_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam int ENTRY_W = XLEN + ILEN;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Fetch sequencer states: no request, request whose data is kept,
  // request whose data belongs to a squashed path.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  // One prefetched instruction together with the address it came from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/scp_fetch_fifo.sv
// Prefetch buffer: DEPTH-entry FIFO of {pc, inst} words. Flush wins over
// push and pop; a push while full is accepted only when a pop frees a slot.
module scp_fetch_fifo
  import scp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic                     push,
  input  logic [ENTRY_W-1:0]       wr_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [ENTRY_W-1:0]       rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]        count_q, count_d;
  logic               do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH_C);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Pointer and occupancy update; a flush empties the buffer outright.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  // Control state of the buffer.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are meaningless while the slot is unoccupied.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/scp_fetch.sv
// Instruction-fetch front end: owns the fetch PC, keeps at most one
// instruction-memory read in flight, buffers returned words with their PC
// and presents them to decode. A redirect flushes the buffer and restarts
// fetch; a read already in flight is then completed and its data dropped.
module scp_fetch #(
  parameter int              XLEN     = scp_pkg::XLEN,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = scp_pkg::RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            res,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc
);

  import scp_pkg::ENTRY_W;
  import scp_pkg::fetch_state_e;
  import scp_pkg::fetch_entry_t;
  import scp_pkg::IDLE;
  import scp_pkg::WAIT;
  import scp_pkg::DRAIN;

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fpc_q, fpc_d;
  logic            req_q, req_d;
  logic [XLEN-1:0] addr_q, addr_d;

  logic            ack;
  logic            pop_ok;
  logic            push;
  logic [XLEN-1:0] redirect_tgt;
  logic [XLEN-1:0] fpc_inc;
  logic [CW-1:0]   cnt_pop;

  fetch_entry_t      wr_entry, head_entry;
  logic [ENTRY_W-1:0] head_bits;
  logic              fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count;

  assign ack          = imem_ack & req_q;
  assign pop_ok       = inst_valid & inst_ready;
  assign redirect_tgt = redirect_pc & ~XLEN'(3);
  assign fpc_inc      = fpc_q + XLEN'(4);
  assign cnt_pop      = fifo_count - {{(CW-1){1'b0}}, pop_ok};

  assign wr_entry.pc   = addr_q;
  assign wr_entry.inst = imem_rdata;
  assign head_entry    = fetch_entry_t'(head_bits);

  scp_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .res     (res),
    .push    (push),
    .wr_data (wr_entry),
    .pop     (pop_ok),
    .flush   (redirect),
    .rd_data (head_bits),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Outputs come from registered state only; an empty buffer reads as zero.
  assign imem_req   = req_q;
  assign imem_addr  = addr_q;
  assign inst_valid = ~fifo_empty;
  assign inst_data  = fifo_empty ? '0 : head_entry.inst;
  assign inst_pc    = fifo_empty ? '0 : head_entry.pc;

  // Fetch sequencer: next state, request and fetch PC. Redirect dominates.
  always_comb begin
    state_d = state_q;
    fpc_d   = fpc_q;
    req_d   = req_q;
    addr_d  = addr_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (redirect) begin
          fpc_d   = redirect_tgt;
          state_d = WAIT;
          req_d   = 1'b1;
          addr_d  = redirect_tgt;
        end else if (!fifo_full || pop_ok) begin
          state_d = WAIT;
          req_d   = 1'b1;
          addr_d  = fpc_q;
        end
      end
      WAIT: begin
        if (redirect) begin
          fpc_d = redirect_tgt;
          if (ack) addr_d = redirect_tgt;
          else     state_d = DRAIN;
        end else if (ack) begin
          push  = 1'b1;
          fpc_d = fpc_inc;
          if ((cnt_pop + CW'(1)) < DEPTH_C) begin
            addr_d = fpc_inc;
          end else begin
            state_d = IDLE;
            req_d   = 1'b0;
          end
        end
      end
      DRAIN: begin
        if (redirect) begin
          fpc_d = redirect_tgt;
          if (ack) begin
            state_d = WAIT;
            addr_d  = redirect_tgt;
          end
        end else if (ack) begin
          state_d = WAIT;
          addr_d  = fpc_q;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // Sequencer registers.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q <= IDLE;
      fpc_q   <= RESET_PC;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
    end
  end

endmodule

// File: tb/tb_scp_fetch.sv
// Bench for scp_fetch: directed scenarios with literal expectations, then
// randomized traffic against a queue-based reference model.
module tb_scp_fetch;

  localparam int DEPTH = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        res;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic        inst_valid, inst_ready;
  logic [31:0] inst_data, inst_pc;
  logic        redirect;
  logic [31:0] redirect_pc;

  always #5 clk = ~clk;

  scp_fetch #(
    .XLEN     (32),
    .DEPTH    (DEPTH),
    .RESET_PC (RST_PC)
  ) dut (
    .clk         (clk),
    .res         (res),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst_data   (inst_data),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  // Reference model: buffered instructions, fetch PC, the request on the
  // bus and whether its data belongs to a squashed path.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        mq[$];
  logic        m_req;
  logic [31:0] m_addr;
  logic [31:0] m_fpc;
  logic        m_discard;

  int vectors = 0;
  int errors  = 0;
  int wcnt    = 0;
  int cur_lat = 1;
  bit rand_mode = 0;
  logic [31:0] last_rdata = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    m_req     = 1'b0;
    m_addr    = RST_PC;
    m_fpc     = RST_PC;
    m_discard = 1'b0;
  endfunction

  function automatic void model_step(input logic red, input logic [31:0] rpc,
                                     input logic rdy, input logic ack_in,
                                     input logic [31:0] rd);
    logic ack;
    ent_t e;
    ack = ack_in && m_req;
    if (red) begin
      mq.delete();
      m_fpc = {rpc[31:2], 2'b00};
      if (m_req && !ack) begin
        m_discard = 1'b1;
      end else begin
        m_req     = 1'b1;
        m_addr    = m_fpc;
        m_discard = 1'b0;
      end
    end else begin
      if (mq.size() > 0 && rdy) void'(mq.pop_front());
      if (m_req && ack) begin
        if (m_discard) begin
          m_discard = 1'b0;
          m_addr    = m_fpc;
        end else begin
          e.pc   = m_addr;
          e.inst = rd;
          mq.push_back(e);
          m_fpc = m_fpc + 32'd4;
          if (mq.size() < DEPTH) m_addr = m_fpc;
          else                   m_req  = 1'b0;
        end
      end else if (!m_req && mq.size() < DEPTH) begin
        m_req  = 1'b1;
        m_addr = m_fpc;
      end
    end
  endfunction

  // Compare every cycle, mid-way between active edges.
  always @(negedge clk) begin
    chk("imem_req", {31'b0, imem_req}, {31'b0, m_req});
    chk("imem_addr", imem_addr, m_addr);
    chk("inst_valid", {31'b0, inst_valid}, {31'b0, (mq.size() > 0)});
    chk("inst_data", inst_data, (mq.size() > 0) ? mq[0].inst : 32'h0);
    chk("inst_pc", inst_pc, (mq.size() > 0) ? mq[0].pc : 32'h0);
  end

  // One clock of stimulus; the memory acks after cur_lat cycles of request.
  task automatic cyc(input logic red, input logic [31:0] rpc, input logic rdy, input logic noise);
    logic ack_d, req_pre;
    req_pre     = imem_req;
    ack_d       = imem_req && (wcnt >= cur_lat - 1);
    redirect    = red;
    redirect_pc = rpc;
    inst_ready  = rdy;
    imem_ack    = ack_d | (noise & ~imem_req);
    imem_rdata  = $urandom;
    if (ack_d) last_rdata = imem_rdata;
    @(posedge clk);
    if (!res) model_step(redirect, redirect_pc, inst_ready, imem_ack, imem_rdata);
    if (ack_d) begin
      wcnt = 0;
      if (rand_mode) cur_lat = $urandom_range(1, 4);
    end else if (req_pre) begin
      wcnt++;
    end
    #1;
  endtask

  task automatic apply_reset();
    res = 1'b1;
    model_reset();
    wcnt       = 0;
    redirect   = 1'b0;
    inst_ready = 1'b0;
    imem_ack   = 1'b0;
    @(posedge clk);
    #1;
    res = 1'b0;
  endtask

  initial begin
    res = 1'b1;
    imem_ack = 1'b0; imem_rdata = 32'h0; inst_ready = 1'b0;
    redirect = 1'b0; redirect_pc = 32'h0;
    model_reset();
    @(posedge clk); #1;
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_addr", imem_addr, RST_PC);
    chk("rst_valid", {31'b0, inst_valid}, 32'h0);
    chk("rst_data", inst_data, 32'h0);
    @(posedge clk); #1;
    res = 1'b0;

    // Streaming: ack every cycle, decode always ready.
    cur_lat = 1;
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk("A_req", {31'b0, imem_req}, 32'h1);
    chk("A_addr0", imem_addr, 32'h0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk("A_addr1", imem_addr, 32'h4);
    chk("A_valid", {31'b0, inst_valid}, 32'h1);
    chk("A_pc0", inst_pc, 32'h0);
    for (int i = 2; i < 10; i++) begin
      cyc(1'b0, 32'h0, 1'b1, 1'b0);
      chk("A_addr_seq", imem_addr, 32'(4 * i));
      chk("A_pc_seq", inst_pc, 32'(4 * (i - 1)));
    end

    // Back-pressure: buffer fills, fetch stops, then drains in order.
    apply_reset();
    cur_lat = 1;
    for (int i = 0; i < 5; i++) cyc(1'b0, 32'h0, 1'b0, 1'b0);
    chk("B_full_req", {31'b0, imem_req}, 32'h0);
    chk("B_head", inst_pc, 32'h0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    chk("B_hold_req", {31'b0, imem_req}, 32'h0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk("B_pc4", inst_pc, 32'h4);
    chk("B_resume_req", {31'b0, imem_req}, 32'h1);
    chk("B_resume_addr", imem_addr, 32'h10);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk("B_pc8", inst_pc, 32'h8);
    chk("B_addr20", imem_addr, 32'h14);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk("B_pc12", inst_pc, 32'hc);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk("B_pc16", inst_pc, 32'h10);

    // Slow memory: request held three cycles.
    apply_reset();
    cur_lat = 3;
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk("C_hold_req", {31'b0, imem_req}, 32'h1);
    chk("C_hold_addr", imem_addr, 32'h0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk("C_hold_addr2", imem_addr, 32'h0);
    chk("C_no_valid", {31'b0, inst_valid}, 32'h0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk("C_valid", {31'b0, inst_valid}, 32'h1);
    chk("C_data", inst_data, last_rdata);
    chk("C_next_addr", imem_addr, 32'h4);

    // Redirect while a read is in flight: its data is dropped.
    apply_reset();
    cur_lat = 1;
    for (int i = 0; i < 20 && imem_addr != 32'h20; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk("D_reach", imem_addr, 32'h20);
    cur_lat = 3;
    cyc(1'b1, 32'h105, 1'b1, 1'b0);
    chk("D_flush_valid", {31'b0, inst_valid}, 32'h0);
    chk("D_drain_addr", imem_addr, 32'h20);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk("D_drain_addr2", imem_addr, 32'h20);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk("D_new_addr", imem_addr, 32'h104);
    chk("D_dropped", {31'b0, inst_valid}, 32'h0);
    cur_lat = 1;
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk("D_first_pc", inst_pc, 32'h104);
    chk("D_first_data", inst_data, last_rdata);

    // Redirect together with an ack and a pop at two buffered entries.
    apply_reset();
    cur_lat = 1;
    for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 1'b0, 1'b0);
    chk("E_head", inst_pc, 32'h0);
    chk("E_addr", imem_addr, 32'h8);
    cyc(1'b1, 32'h200, 1'b1, 1'b0);
    chk("E_empty", {31'b0, inst_valid}, 32'h0);
    chk("E_addr_tgt", imem_addr, 32'h200);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk("E_pc", inst_pc, 32'h200);
    chk("E_data", inst_data, last_rdata);

    // Reset during an outstanding read; a late ack must be ignored.
    apply_reset();
    cur_lat = 1;
    for (int i = 0; i < 30 && imem_addr != 32'h40; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk("F_reach", imem_addr, 32'h40);
    cur_lat = 5;
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    res = 1'b1;
    imem_ack = 1'b1;
    model_reset();
    wcnt = 0;
    #1;
    chk("F_async_req", {31'b0, imem_req}, 32'h0);
    chk("F_async_valid", {31'b0, inst_valid}, 32'h0);
    chk("F_async_addr", imem_addr, RST_PC);
    @(posedge clk); #1;
    res = 1'b0;
    cur_lat = 1;
    cyc(1'b0, 32'h0, 1'b1, 1'b1);
    chk("F_restart_req", {31'b0, imem_req}, 32'h1);
    chk("F_restart_addr", imem_addr, RST_PC);
    chk("F_late_ack", {31'b0, inst_valid}, 32'h0);

    // Randomized traffic.
    rand_mode = 1;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        apply_reset();
      end else begin
        cyc(($urandom_range(0, 19) == 0), $urandom, ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 7) == 0));
      end
    end

    redirect = 1'b0;
    imem_ack = 1'b0;
    @(posedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/scp_fetch.md
Name: scp_fetch

Overview:
- Instruction-fetch front end placed directly upstream of the scp core datapath.
- Owns the fetch PC and issues word reads to instruction memory over a req/ack handshake that may take several cycles.
- Buffers returned instructions, each tagged with its PC, in a small prefetch FIFO.
- Hands them to decode over valid/ready; a branch/jump redirect from execute flushes the buffer and restarts fetch.

Parameters:
- XLEN, 32, address and instruction width.
- DEPTH, 4, prefetch FIFO entries (power of two, >=2).
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  system clock, rising edge.
- res  in  1  asynchronous, active-high reset.
- imem_req  out  1  read request to instruction memory.
- imem_addr  out  XLEN  word address of request, bits[1:0] always 0.
- imem_ack  in  1  memory has returned data this cycle, sampled at posedge while imem_req=1.
- imem_rdata  in  XLEN  instruction word, valid when imem_ack=1.
- inst_valid  out  1  FIFO head holds a valid instruction.
- inst_data  out  XLEN  head instruction.
- inst_pc  out  XLEN  PC of head instruction.
- inst_ready  in  1  decode accepts head this cycle.
- redirect  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  XLEN  new fetch target; bits[1:0] forced to 0.

Behaviour:
- Reset values (asynchronous): imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst_data=0, inst_pc=0, FIFO count=0, fpc=RESET_PC, state=IDLE.
- All outputs are registered or driven from registered state only; no combinational path from any input to any output.
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: request outstanding, data to be kept.
  - DRAIN: request outstanding, data to be discarded.
- IDLE -> WAIT when space exists (count < DEPTH). Sets imem_req=1 and imem_addr=fpc at that edge. The first request appears at the first posedge after res deasserts.
- Request signals: imem_req and imem_addr are held stable until the edge where imem_ack=1 is sampled. At most one request is outstanding.
- WAIT with ack:
  - Write {imem_rdata, imem_addr} into the FIFO; fpc <= fpc+4 (32-bit wrap, no exception).
  - If count_after_this_edge < DEPTH, stay in WAIT with the new address (back-to-back, one instruction per cycle sustained).
  - Otherwise go to IDLE with imem_req=0.
- Ack-to-output latency: a written entry drives inst_valid on the cycle after the ack edge, when the FIFO was empty.
- Decode handshake:
  - Pop when inst_valid && inst_ready at a posedge.
  - inst_data and inst_pc must not change while inst_valid=1 and inst_ready=0.
- Simultaneous push and pop is legal at any count, including full; count stays unchanged.
- Redirect has the highest priority at every posedge:
  - Flush the FIFO (count=0, inst_valid=0 next cycle). A pop in the same cycle is discarded.
  - fpc <= {redirect_pc[31:2], 2'b00}.
  - From IDLE: go to WAIT, request the new fpc.
  - From WAIT without ack: go to DRAIN.
  - From WAIT with ack on the same edge: data discarded, go to WAIT at the new fpc.
  - From DRAIN: target updated, stay in DRAIN.
- DRAIN with ack: data discarded, then go to WAIT with imem_addr = the current fpc.
- Wrong-path data never enters the FIFO.
- Reset mid-transaction returns everything to the reset values immediately. A late imem_ack after reset is ignored because imem_req=0.

Decomposition:
- Shared package scp_pkg holds:
  - XLEN and ILEN constants;
  - the RESET_PC default;
  - the fetch FSM state enum (IDLE, WAIT, DRAIN);
  - the fetch entry typedef {pc, inst}.
- One sub-module, scp_fetch_fifo: synchronous DEPTH-entry FIFO with push, pop, flush, full, empty and count outputs. Flush takes priority over push and pop.

Test Plan:
- Reset release, memory acks every cycle, inst_ready=1 -> imem_addr sequence 0,4,8,12,... on consecutive cycles; inst_pc 0 appears the cycle after the first ack; throughput one instruction per cycle.
- inst_ready=0, DEPTH=4, ack latency 1 -> exactly 4 entries accepted, then imem_req=0. Raise inst_ready -> entries 0,4,8,12 drain in order, fetch resumes at 16.
- Ack latency 3 cycles -> imem_req and imem_addr stay stable for 3 cycles; inst_data equals the imem_rdata captured at each ack.
- Redirect to 0x104 while a request to 0x20 is outstanding -> inst_valid=0 next cycle; the ack for 0x20 is discarded; next imem_addr=0x104 with bits[1:0]=0; first inst_pc=0x104.
- Redirect on the same edge as an ack and a pop at count=2 -> FIFO empty, ack data discarded, next imem_addr=redirect target.
- Assert res for 1 cycle during WAIT at 0x40 -> imem_req=0, inst_valid=0 immediately; after release the first request is at RESET_PC.
